// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access
//   clk, rst                          rising-edge clock, async active-high reset
//   imem_addr/rmask -> imem_rdata/resp fetch request pulse in, fetch completion out
//   dmem_addr/rmask/wmask/wdata -> dmem_rdata/resp  data request pulse in, completion out
//   mem_addr/rmask/wmask/wdata, mem_rdata/resp      unified memory port
//   busy                              any request pending or outstanding
module mem_port_arbiter #(
   parameter bit DMEM_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] imem_addr,
   input  logic [3:0]  imem_rmask,
   output logic [31:0] imem_rdata,
   output logic        imem_resp,
   input  logic [31:0] dmem_addr,
   input  logic [3:0]  dmem_rmask,
   input  logic [3:0]  dmem_wmask,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic        dmem_resp,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_rmask,
   output logic [3:0]  mem_wmask,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_resp,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
   state_t state, state_d;
   logic        i_v, d_v;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [3:0]  i_rmask, d_rmask, d_wmask;
   logic        i_take, d_take, i_iss, d_iss;
   // a side completing this cycle is free again, so its next pulse is accepted
   assign i_take = (|imem_rmask) & ~i_v & ~((state == BUSY_I) & ~mem_resp);
   assign d_take = (|(dmem_rmask | dmem_wmask)) & ~d_v & ~((state == BUSY_D) & ~mem_resp);
   assign d_iss  = (state == IDLE) & d_v & (~i_v | DMEM_FIRST);
   assign i_iss  = (state == IDLE) & i_v & ~d_iss;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_v     <= 1'b0;
         i_addr  <= '0;
         i_rmask <= '0;
      end else if (i_take) begin
         i_v     <= 1'b1;
         i_addr  <= imem_addr;
         i_rmask <= imem_rmask;
      end else if (i_iss) begin
         i_v     <= 1'b0;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_v     <= 1'b0;
         d_addr  <= '0;
         d_rmask <= '0;
         d_wmask <= '0;
         d_wdata <= '0;
      end else if (d_take) begin
         d_v     <= 1'b1;
         d_addr  <= dmem_addr;
         d_rmask <= dmem_rmask;
         d_wmask <= dmem_wmask;
         d_wdata <= dmem_wdata;
      end else if (d_iss) begin
         d_v     <= 1'b0;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end
   always_comb begin
      state_d   = state;
      mem_addr  = '0;
      mem_rmask = '0;
      mem_wmask = '0;
      mem_wdata = '0;
      imem_resp = 1'b0;
      dmem_resp = 1'b0;
      case (state)
         IDLE: begin
            if (d_iss) begin
               mem_addr  = d_addr & ~32'h3;
               mem_rmask = d_rmask;
               mem_wmask = d_wmask;
               mem_wdata = d_wdata;
               state_d   = BUSY_D;
            end else if (i_iss) begin
               mem_addr  = i_addr & ~32'h3;
               mem_rmask = i_rmask;
               state_d   = BUSY_I;
            end
         end
         BUSY_I: begin
            imem_resp = mem_resp;
            state_d   = mem_resp ? IDLE : BUSY_I;
         end
         BUSY_D: begin
            dmem_resp = mem_resp;
            state_d   = mem_resp ? IDLE : BUSY_D;
         end
         default: state_d = IDLE;
      endcase
   end
   assign imem_rdata = mem_rdata;
   assign dmem_rdata = mem_rdata;
   assign busy       = (state != IDLE) | i_v | d_v;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: checks both tie-break variants against a transaction-level model
module tb_mem_port_arbiter;
   logic        clk = 1'b0, rst = 1'b1;
   logic [31:0] imem_addr = '0, dmem_addr = '0, dmem_wdata = '0;
   logic [3:0]  imem_rmask = '0, dmem_rmask = '0, dmem_wmask = '0;
   logic        auto_mem = 1'b0, man_resp = 1'b0;
   logic [31:0] man_rdata = '0;
   logic        a_resp [2] = '{1'b0, 1'b0};
   logic [31:0] a_rdata [2] = '{32'h0, 32'h0};
   logic        mem_resp [2];
   logic [31:0] mem_rdata [2];
   logic [31:0] o_irdata [2], o_drdata [2], o_maddr [2], o_mwdata [2];
   logic [3:0]  o_mr [2], o_mw [2];
   logic        o_ir [2], o_dr [2], o_busy [2];
   int n_tot = 0, n_pass = 0;
   // side 0 = imem, side 1 = dmem; owner -1 = port free
   logic        m_pv [2][2] = '{default: 1'b0};
   logic [31:0] m_pa [2][2], m_pd [2][2];
   logic [3:0]  m_pr [2][2], m_pw [2][2];
   int          m_own [2] = '{-1, -1};
   int          acc_n [2][2] = '{default: 0};
   int          resp_n [2][2] = '{default: 0};
   int          cnt [2] = '{0, 0};
   assign mem_resp[0]  = auto_mem ? a_resp[0] : man_resp;
   assign mem_resp[1]  = auto_mem ? a_resp[1] : man_resp;
   assign mem_rdata[0] = auto_mem ? a_rdata[0] : man_rdata;
   assign mem_rdata[1] = auto_mem ? a_rdata[1] : man_rdata;
   always #5 clk = ~clk;
   mem_port_arbiter #(.DMEM_FIRST(1'b0)) u0 (
      .clk(clk), .rst(rst),
      .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(o_irdata[0]), .imem_resp(o_ir[0]),
      .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
      .dmem_rdata(o_drdata[0]), .dmem_resp(o_dr[0]),
      .mem_addr(o_maddr[0]), .mem_rmask(o_mr[0]), .mem_wmask(o_mw[0]), .mem_wdata(o_mwdata[0]),
      .mem_rdata(mem_rdata[0]), .mem_resp(mem_resp[0]), .busy(o_busy[0]));
   mem_port_arbiter #(.DMEM_FIRST(1'b1)) u1 (
      .clk(clk), .rst(rst),
      .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(o_irdata[1]), .imem_resp(o_ir[1]),
      .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
      .dmem_rdata(o_drdata[1]), .dmem_resp(o_dr[1]),
      .mem_addr(o_maddr[1]), .mem_rmask(o_mr[1]), .mem_wmask(o_mw[1]), .mem_wdata(o_mwdata[1]),
      .mem_rdata(mem_rdata[1]), .mem_resp(mem_resp[1]), .busy(o_busy[1]));
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask
   // instance k has dmem priority when k == 1
   function automatic int win(input int k);
      if (m_own[k] >= 0) return -1;
      if (m_pv[k][1] && (!m_pv[k][0] || k == 1)) return 1;
      if (m_pv[k][0]) return 0;
      return -1;
   endfunction
   function automatic bit free(input int s);
      return !m_pv[0][s] && m_own[0] != s && !m_pv[1][s] && m_own[1] != s;
   endfunction
   function automatic bit model_idle();
      return m_own[0] < 0 && m_own[1] < 0 && !m_pv[0][0] && !m_pv[0][1] && !m_pv[1][0] && !m_pv[1][1];
   endfunction
   initial begin : model
      logic acc [2];
      int w;
      forever begin
         @(posedge clk or posedge rst);
         for (int k = 0; k < 2; k++) begin
            if (rst) begin
               m_pv[k][0] = 1'b0;
               m_pv[k][1] = 1'b0;
               m_own[k]   = -1;
            end else begin
               acc[0] = imem_rmask != 0 && !m_pv[k][0] && !(m_own[k] == 0 && !mem_resp[k]);
               acc[1] = (dmem_rmask | dmem_wmask) != 0 && !m_pv[k][1] && !(m_own[k] == 1 && !mem_resp[k]);
               w = win(k);
               if (w >= 0) begin
                  m_pv[k][w] = 1'b0;
                  m_own[k]   = w;
               end else if (m_own[k] >= 0 && mem_resp[k]) m_own[k] = -1;
               if (acc[0]) begin
                  m_pv[k][0] = 1'b1; m_pa[k][0] = imem_addr; m_pr[k][0] = imem_rmask;
                  m_pw[k][0] = 4'h0; m_pd[k][0] = 32'h0; acc_n[k][0]++;
               end
               if (acc[1]) begin
                  m_pv[k][1] = 1'b1; m_pa[k][1] = dmem_addr; m_pr[k][1] = dmem_rmask;
                  m_pw[k][1] = dmem_wmask; m_pd[k][1] = dmem_wdata; acc_n[k][1]++;
               end
            end
         end
      end
   end
   initial begin : responder
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < 2; k++) begin
            a_resp[k] = 1'b0;
            if (auto_mem && m_own[k] >= 0) begin
               if (cnt[k] == 0) cnt[k] = $urandom_range(1, 8);
               cnt[k]--;
               if (cnt[k] == 0) begin
                  a_resp[k]  = 1'b1;
                  a_rdata[k] = $urandom;
               end
            end
         end
      end
   end
   initial begin : compare
      int w;
      logic [31:0] ea, ed;
      logic [3:0] er, ew;
      logic eir, edr;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            w = win(k);
            ea = '0; ed = '0; er = '0; ew = '0;
            if (w >= 0) begin
               ea = m_pa[k][w] & ~32'h3;
               er = m_pr[k][w];
               ew = m_pw[k][w];
               ed = m_pd[k][w];
            end
            eir = m_own[k] == 0 && mem_resp[k];
            edr = m_own[k] == 1 && mem_resp[k];
            chk($sformatf("u%0d mem_addr", k), o_maddr[k], ea);
            chk($sformatf("u%0d mem_rmask", k), o_mr[k], er);
            chk($sformatf("u%0d mem_wmask", k), o_mw[k], ew);
            chk($sformatf("u%0d mem_wdata", k), o_mwdata[k], ed);
            chk($sformatf("u%0d imem_resp", k), o_ir[k], eir);
            chk($sformatf("u%0d dmem_resp", k), o_dr[k], edr);
            chk($sformatf("u%0d busy", k), o_busy[k], m_own[k] >= 0 || m_pv[k][0] || m_pv[k][1]);
            if (eir) chk($sformatf("u%0d imem_rdata", k), o_irdata[k], mem_rdata[k]);
            if (edr) chk($sformatf("u%0d dmem_rdata", k), o_drdata[k], mem_rdata[k]);
            if (o_ir[k]) resp_n[k][0]++;
            if (o_dr[k]) resp_n[k][1]++;
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic mid();
      @(negedge clk);
      #1;
   endtask
   task automatic idle_in();
      imem_rmask = '0;
      dmem_rmask = '0;
      dmem_wmask = '0;
   endtask
   initial begin : timeout
      #1000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
   initial begin : main
      int req_n, cyc, d;
      tick();
      tick();
      chk("reset busy", o_busy[1], 1'b0);
      chk("reset mem_rmask", o_mr[1], 4'h0);
      chk("reset mem_addr", o_maddr[1], 32'h0);
      rst = 1'b0;
      // single fetch
      tick();
      imem_addr = 32'h60000000; imem_rmask = 4'hF;
      tick(); idle_in();
      mid();
      chk("fetch mem_addr", o_maddr[1], 32'h60000000);
      chk("fetch mem_rmask", o_mr[1], 4'hF);
      tick(); man_resp = 1'b1; man_rdata = 32'h00000013;
      mid();
      chk("fetch imem_resp", o_ir[1], 1'b1);
      chk("fetch imem_rdata", o_irdata[1], 32'h00000013);
      chk("fetch no reissue", o_mr[1], 4'h0);
      tick(); man_resp = 1'b0;
      // simultaneous fetch and store, both tie-break settings
      tick();
      imem_addr = 32'h60000100; imem_rmask = 4'hF;
      dmem_addr = 32'h60001006; dmem_wmask = 4'hC; dmem_wdata = 32'hDEADBEEF;
      tick(); idle_in();
      mid();
      chk("tie d1 mem_addr", o_maddr[1], 32'h60001004);
      chk("tie d1 mem_wmask", o_mw[1], 4'hC);
      chk("tie d1 mem_rmask", o_mr[1], 4'h0);
      chk("tie d1 mem_wdata", o_mwdata[1], 32'hDEADBEEF);
      chk("tie d0 mem_addr", o_maddr[0], 32'h60000100);
      chk("tie d0 mem_rmask", o_mr[0], 4'hF);
      tick(); man_resp = 1'b1;
      mid();
      chk("tie d1 dmem_resp", o_dr[1], 1'b1);
      chk("tie d0 imem_resp", o_ir[0], 1'b1);
      tick(); man_resp = 1'b0;
      mid();
      chk("tie d1 second mem_rmask", o_mr[1], 4'hF);
      chk("tie d1 second mem_addr", o_maddr[1], 32'h60000100);
      chk("tie d0 second mem_wmask", o_mw[0], 4'hC);
      chk("tie d0 second mem_addr", o_maddr[0], 32'h60001004);
      tick(); man_resp = 1'b1;
      mid();
      chk("tie d1 imem_resp", o_ir[1], 1'b1);
      chk("tie d0 dmem_resp", o_dr[0], 1'b1);
      tick(); man_resp = 1'b0;
      // slow memory, data request waits behind outstanding fetch
      imem_addr = 32'h60000200; imem_rmask = 4'hF;
      tick(); idle_in();
      tick();
      tick();
      dmem_addr = 32'h60002000; dmem_rmask = 4'hF;
      tick(); idle_in();
      mid();
      chk("slow busy", o_busy[1], 1'b1);
      chk("slow no issue a", o_mr[1], 4'h0);
      tick();
      mid();
      chk("slow no issue b", o_mr[1], 4'h0);
      tick(); man_resp = 1'b1;
      mid();
      chk("slow imem_resp", o_ir[1], 1'b1);
      tick(); man_resp = 1'b0;
      mid();
      chk("slow dmem mem_rmask", o_mr[1], 4'hF);
      chk("slow dmem mem_addr", o_maddr[1], 32'h60002000);
      tick(); man_resp = 1'b1;
      mid();
      chk("slow dmem_resp", o_dr[1], 1'b1);
      tick(); man_resp = 1'b0;
      // duplicate fetch pulse while outstanding is dropped
      imem_addr = 32'h60000300; imem_rmask = 4'hF;
      tick(); idle_in();
      tick();
      imem_addr = 32'h60000400; imem_rmask = 4'hF;
      tick(); idle_in(); man_resp = 1'b1;
      mid();
      chk("dup imem_resp", o_ir[1], 1'b1);
      tick(); man_resp = 1'b0;
      mid();
      chk("dup busy", o_busy[1], 1'b0);
      chk("dup no issue", o_mr[1], 4'h0);
      // reset during an outstanding data read
      tick();
      dmem_addr = 32'h60003000; dmem_rmask = 4'hF;
      tick(); idle_in();
      tick();
      rst = 1'b1;
      #1;
      chk("abort busy", o_busy[1], 1'b0);
      chk("abort mem_addr", o_maddr[1], 32'h0);
      tick(); rst = 1'b0;
      tick(); man_resp = 1'b1;
      mid();
      chk("abort dmem_resp", o_dr[1], 1'b0);
      chk("abort busy after", o_busy[1], 1'b0);
      tick(); man_resp = 1'b0;
      tick();
      // random traffic with random memory latency
      auto_mem = 1'b1;
      req_n = 0;
      cyc = 0;
      for (int k = 0; k < 2; k++) begin
         acc_n[k][0] = 0; acc_n[k][1] = 0; resp_n[k][0] = 0; resp_n[k][1] = 0;
      end
      while (req_n < 1000 && cyc < 40000) begin
         idle_in();
         if (free(0) && $urandom_range(0, 2) == 0) begin
            imem_addr = $urandom;
            imem_rmask = 4'($urandom_range(1, 15));
            req_n++;
         end
         if (req_n < 1000 && free(1) && $urandom_range(0, 2) == 0) begin
            dmem_addr = $urandom;
            if ($urandom_range(0, 1) == 1) dmem_rmask = 4'($urandom_range(1, 15));
            else begin
               dmem_wmask = 4'($urandom_range(1, 15));
               dmem_wdata = $urandom;
            end
            req_n++;
         end
         tick();
         cyc++;
      end
      idle_in();
      d = 0;
      while (!model_idle() && d < 100) begin
         tick();
         d++;
      end
      tick();
      chk("random drained", d < 100, 1'b1);
      chk("random request count", req_n, 1000);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("u%0d accepted", k), acc_n[k][0] + acc_n[k][1], req_n);
         chk($sformatf("u%0d imem resp count", k), resp_n[k][0], acc_n[k][0]);
         chk($sformatf("u%0d dmem resp count", k), resp_n[k][1], acc_n[k][1]);
      end
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
